// File: rtl/vsm_sequencer_if.sv
// Control bus between the VSM sequencer, its program ROM and the datapath
// strobes. The sequencer side drives the strobes and Addr.
interface vsm_sequencer_if;
  logic       Run;
  logic [3:0] Instr;
  logic [3:0] Addr;
  logic       LoadIR;
  logic       LatchA;
  logic       LatchB;
  logic       LatchOut;
  logic       ClearA;
  logic       EnableA;
  logic       EnableB;
  logic       EnableAlu;
  logic       AluSub;
  logic       Busy;
  logic       Halted;

  modport master (
    input  Run, Instr,
    output Addr, LoadIR, LatchA, LatchB, LatchOut, ClearA,
           EnableA, EnableB, EnableAlu, AluSub, Busy, Halted
  );

  modport slave (
    output Run, Instr,
    input  Addr, LoadIR, LatchA, LatchB, LatchOut, ClearA,
           EnableA, EnableB, EnableAlu, AluSub, Busy, Halted
  );
endinterface

// File: rtl/vsm_sequencer.sv
// Microcoded sequencer for a tiny accumulator machine: fetch/decode/execute
// with falling-edge registered strobes so they are stable while MainClock is high.
module vsm_sequencer (
  input  logic           MainClock,
  input  logic           Reset,
  vsm_sequencer_if.master bus
);

  localparam int unsigned AW = 4;
  localparam int unsigned IW = 4;

  localparam logic [IW-1:0] OP_LDA  = 4'h1;
  localparam logic [IW-1:0] OP_LDB  = 4'h2;
  localparam logic [IW-1:0] OP_ADD  = 4'h3;
  localparam logic [IW-1:0] OP_SUB  = 4'h4;
  localparam logic [IW-1:0] OP_OUTA = 4'h5;
  localparam logic [IW-1:0] OP_OUTB = 4'h6;
  localparam logic [IW-1:0] OP_CLRA = 4'h7;
  localparam logic [IW-1:0] OP_HLT  = 4'hF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC1  = 3'd3,
    EXEC2  = 3'd4,
    HALT   = 3'd5
  } state_t;

  typedef struct packed {
    logic load_ir;
    logic latch_a;
    logic latch_b;
    logic latch_out;
    logic clear_a;
    logic en_a;
    logic en_b;
    logic en_alu;
    logic alu_sub;
  } ctrl_t;

  state_t        state, state_nxt;
  logic [AW-1:0] pc, pc_nxt;
  logic [IW-1:0] ir, ir_nxt;
  ctrl_t         ctrl, ctrl_nxt;
  logic          busy, busy_nxt;
  logic          halted, halted_nxt;

  // State, PC, IR and all outputs update together on the falling edge
  always_ff @(negedge MainClock or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      pc     <= '0;
      ir     <= '0;
      ctrl   <= '0;
      busy   <= 1'b0;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      ir     <= ir_nxt;
      ctrl   <= ctrl_nxt;
      busy   <= busy_nxt;
      halted <= halted_nxt;
    end
  end

  // Next state, then the strobes that belong to that next state
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ir_nxt     = ir;
    ctrl_nxt   = '0;
    busy_nxt   = 1'b0;
    halted_nxt = 1'b0;

    case (state)
      IDLE:   if (bus.Run) state_nxt = FETCH;
      FETCH:  state_nxt = DECODE;
      DECODE: begin
        ir_nxt    = bus.Instr;
        state_nxt = EXEC1;
      end
      EXEC1: begin
        if (ir == OP_HLT) begin
          state_nxt = HALT;
        end else if (ir == OP_ADD || ir == OP_SUB) begin
          state_nxt = EXEC2;
        end else begin
          pc_nxt    = pc + AW'(1);
          state_nxt = bus.Run ? FETCH : IDLE;
        end
      end
      EXEC2: begin
        pc_nxt    = pc + AW'(1);
        state_nxt = bus.Run ? FETCH : IDLE;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase

    case (state_nxt)
      FETCH: ctrl_nxt.load_ir = 1'b1;
      EXEC1: begin
        case (ir_nxt)
          OP_LDA: ctrl_nxt.latch_a = 1'b1;
          OP_LDB: ctrl_nxt.latch_b = 1'b1;
          OP_ADD, OP_SUB: begin
            ctrl_nxt.en_alu  = 1'b1;
            ctrl_nxt.alu_sub = (ir_nxt == OP_SUB);
          end
          OP_OUTA: begin
            ctrl_nxt.en_a      = 1'b1;
            ctrl_nxt.latch_out = 1'b1;
          end
          OP_OUTB: begin
            ctrl_nxt.en_b      = 1'b1;
            ctrl_nxt.latch_out = 1'b1;
          end
          OP_CLRA: ctrl_nxt.clear_a = 1'b1;
          default: ctrl_nxt = '0;
        endcase
      end
      EXEC2: begin
        ctrl_nxt.en_alu  = 1'b1;
        ctrl_nxt.alu_sub = (ir_nxt == OP_SUB);
        ctrl_nxt.latch_a = 1'b1;
      end
      default: ctrl_nxt = '0;
    endcase

    busy_nxt   = (state_nxt != IDLE) && (state_nxt != HALT);
    halted_nxt = (state_nxt == HALT);
  end

  assign bus.Addr      = pc;
  assign bus.LoadIR    = ctrl.load_ir;
  assign bus.LatchA    = ctrl.latch_a;
  assign bus.LatchB    = ctrl.latch_b;
  assign bus.LatchOut  = ctrl.latch_out;
  assign bus.ClearA    = ctrl.clear_a;
  assign bus.EnableA   = ctrl.en_a;
  assign bus.EnableB   = ctrl.en_b;
  assign bus.EnableAlu = ctrl.en_alu;
  assign bus.AluSub    = ctrl.alu_sub;
  assign bus.Busy      = busy;
  assign bus.Halted    = halted;

endmodule
